// File: rtl/int_controller.sv
// Three-line interrupt controller: sync, edge/level pending, mask + fixed priority, ack/EOI handshake.
// Optional ack watchdog enabled by defining INTC_TIMEOUT_EN.
module int_controller #(
  parameter int SYNC_STAGES    = 2,
  parameter int PRIO_LOW_FIRST = 1,
  parameter int ACK_TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] irq_in,
  input  logic       cfg_we,
  input  logic [7:0] cfg_data,
  input  logic       int_ack,
  input  logic       int_eoi,
  output logic [2:0] int_req,
  output logic [7:0] status
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} stateT;

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  stateT      state, stateNext;
  logic [2:0] syncChain [SYNC_STAGES];
  logic [2:0] syncSig, syncD, rise;
  logic [2:0] maskReg, modeReg;
  logic       globalEn;
  logic [2:0] pending, eligible, winner;
  logic [2:0] cur, curNext, intReqNext;
  logic [2:0] inService, inServiceNext, clrPend;
  logic       timeoutHit, toExpire, timeoutFlag;

  assign syncSig  = syncChain[SYNC_STAGES-1];
  assign rise     = syncSig & ~syncD;
  assign eligible = pending & maskReg & {3{globalEn}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) syncChain[i] <= '0;
      syncD <= '0;
    end else begin
      syncChain[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) syncChain[i] <= syncChain[i-1];
      syncD <= syncSig;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      maskReg  <= '0;
      modeReg  <= '0;
      globalEn <= 1'b0;
    end else if (cfg_we) begin
      maskReg  <= cfg_data[2:0];
      modeReg  <= cfg_data[5:3];
      globalEn <= cfg_data[7];
    end
  end

  // Edge lines latch (a new edge beats a same-cycle clear); level lines track the synced input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (modeReg & ((pending & ~clrPend) | rise)) | (~modeReg & syncSig);
  end

  always_comb begin
    winner = '0;
    if (PRIO_LOW_FIRST != 0) begin
      if (eligible[0])      winner = 3'b001;
      else if (eligible[1]) winner = 3'b010;
      else if (eligible[2]) winner = 3'b100;
    end else begin
      if (eligible[2])      winner = 3'b100;
      else if (eligible[1]) winner = 3'b010;
      else if (eligible[0]) winner = 3'b001;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur       <= '0;
      int_req   <= '0;
      inService <= '0;
    end else begin
      state     <= stateNext;
      cur       <= curNext;
      int_req   <= intReqNext;
      inService <= inServiceNext;
    end
  end

  always_comb begin
    stateNext     = state;
    curNext       = cur;
    intReqNext    = int_req;
    inServiceNext = inService;
    clrPend       = '0;
    timeoutHit    = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          stateNext  = REQ;
          curNext    = winner;
          intReqNext = winner;
        end
      end
      REQ: begin
        if (int_ack) begin
          stateNext     = SERVICE;
          intReqNext    = '0;
          inServiceNext = cur;
          clrPend       = cur;
        end else if (!(|(cur & eligible))) begin
          stateNext  = IDLE;
          intReqNext = '0;
        end else if (toExpire) begin
          stateNext  = IDLE;
          intReqNext = '0;
          clrPend    = cur;
          timeoutHit = 1'b1;
        end
      end
      SERVICE: begin
        if (int_eoi) begin
          stateNext     = IDLE;
          inServiceNext = '0;
        end
      end
      default: begin
        stateNext  = IDLE;
        intReqNext = '0;
      end
    endcase
  end

`ifdef INTC_TIMEOUT_EN
  logic [7:0] toCount;

  assign toExpire = (toCount == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            toCount <= '0;
    else if (state == REQ) toCount <= toCount + 8'd1;
    else                   toCount <= '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      timeoutFlag <= 1'b0;
    else if (timeoutHit)             timeoutFlag <= 1'b1;
    else if (cfg_we && cfg_data[6])  timeoutFlag <= 1'b0;
  end
`else
  logic [8:0] unusedCfg;

  assign unusedCfg   = {cfg_data[6], TO_LAST};
  assign toExpire    = 1'b0;
  assign timeoutFlag = 1'b0;
`endif

  assign status = {timeoutFlag, (state != IDLE), inService, pending};

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: default instance plus a high-first, 3-stage sync, short-timeout instance.
module tb_int_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] irqIn = '0, irqIn2 = '0;
  logic       cfgWe = 1'b0, cfgWe2 = 1'b0;
  logic [7:0] cfgData = '0, cfgData2 = '0;
  logic       intAck = 1'b0, intAck2 = 1'b0;
  logic       intEoi = 1'b0, intEoi2 = 1'b0;
  logic [2:0] intReq, intReq2;
  logic [7:0] status, status2;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } expT;
  expT sbq[$];

  always #5 clk = ~clk;

  int_controller dut (
    .clk(clk), .reset(reset), .irq_in(irqIn), .cfg_we(cfgWe), .cfg_data(cfgData),
    .int_ack(intAck), .int_eoi(intEoi), .int_req(intReq), .status(status)
  );

  int_controller #(.SYNC_STAGES(3), .PRIO_LOW_FIRST(0), .ACK_TIMEOUT(4)) dut2 (
    .clk(clk), .reset(reset), .irq_in(irqIn2), .cfg_we(cfgWe2), .cfg_data(cfgData2),
    .int_ack(intAck2), .int_eoi(intEoi2), .int_req(intReq2), .status(status2)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectOut(input string tag, input int sel, input logic [7:0] exp);
    sbq.push_back('{tag, sel, exp});
  endtask

  task automatic checkOutput();
    expT e;
    logic [7:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.sel)
        0:       obs = {5'b0, intReq};
        1:       obs = status;
        2:       obs = {5'b0, intReq2};
        3:       obs = status2;
        default: obs = {status2[7], 7'b0};
      endcase
      compared++;
      assert (obs === e.exp) else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic applyStimulus(input logic [2:0] irq, input logic we, input logic [7:0] data,
                               input logic ack, input logic eoi);
    irqIn = irq; cfgWe = we; cfgData = data; intAck = ack; intEoi = eoi;
    step(1);
    cfgWe = 1'b0; intAck = 1'b0; intEoi = 1'b0;
  endtask

  task automatic applyStimulus2(input logic [2:0] irq, input logic we, input logic [7:0] data,
                                input logic ack, input logic eoi);
    irqIn2 = irq; cfgWe2 = we; cfgData2 = data; intAck2 = ack; intEoi2 = eoi;
    step(1);
    cfgWe2 = 1'b0; intAck2 = 1'b0; intEoi2 = 1'b0;
  endtask

  initial begin
    #3;
    expectOut("reset_req", 0, 8'h00);
    expectOut("reset_status", 1, 8'h00);
    checkOutput();
    step(2);
    reset = 1'b1;

    // Level mode, all lines enabled; latency is three edges from first sample.
    applyStimulus(3'b000, 1'b1, 8'h87, 1'b0, 1'b0);
    applyStimulus(3'b001, 1'b0, 8'h00, 1'b0, 1'b0);
    step(2);
    expectOut("lvl_before_latency", 0, 8'h00);
    checkOutput();
    step(1);
    expectOut("lvl_req", 0, 8'h01);
    expectOut("lvl_req_status", 1, 8'h41);
    checkOutput();
    applyStimulus(3'b001, 1'b0, 8'h00, 1'b1, 1'b0);
    expectOut("lvl_ack_req", 0, 8'h00);
    expectOut("lvl_ack_status", 1, 8'h49);
    checkOutput();
    applyStimulus(3'b001, 1'b0, 8'h00, 1'b0, 1'b1);
    expectOut("lvl_eoi_status", 1, 8'h01);
    expectOut("lvl_eoi_req", 0, 8'h00);
    checkOutput();
    step(1);
    expectOut("lvl_rereq", 0, 8'h01);
    checkOutput();
    applyStimulus(3'b001, 1'b0, 8'h00, 1'b0, 1'b1);
    expectOut("eoi_in_req_ignored", 1, 8'h41);
    checkOutput();
    applyStimulus(3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
    step(4);
    expectOut("lvl_drop_req", 0, 8'h00);
    expectOut("lvl_drop_status", 1, 8'h00);
    checkOutput();

    // Edge mode: two simultaneous edges, low index wins.
    applyStimulus(3'b000, 1'b1, 8'hBF, 1'b0, 1'b0);
    applyStimulus(3'b110, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
    step(2);
    expectOut("edge_req", 0, 8'h02);
    expectOut("edge_req_status", 1, 8'h46);
    checkOutput();
    applyStimulus(3'b000, 1'b0, 8'h00, 1'b1, 1'b0);
    expectOut("edge_ack_status", 1, 8'h54);
    checkOutput();
    applyStimulus(3'b000, 1'b0, 8'h00, 1'b0, 1'b1);
    expectOut("edge_eoi_status", 1, 8'h04);
    checkOutput();
    step(1);
    expectOut("edge_next_req", 0, 8'h04);
    checkOutput();
    applyStimulus(3'b000, 1'b0, 8'h00, 1'b1, 1'b1);
    expectOut("ack_eoi_same_cycle", 1, 8'h60);
    checkOutput();
    applyStimulus(3'b000, 1'b0, 8'h00, 1'b0, 1'b1);
    expectOut("edge_final_eoi", 1, 8'h00);
    checkOutput();

    // Masked edge still latches; mask change takes effect next cycle.
    applyStimulus(3'b000, 1'b1, 8'hB8, 1'b0, 1'b0);
    applyStimulus(3'b001, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
    step(2);
    expectOut("masked_req", 0, 8'h00);
    expectOut("masked_status", 1, 8'h01);
    checkOutput();
    applyStimulus(3'b000, 1'b0, 8'h00, 1'b1, 1'b0);
    expectOut("ack_in_idle_ignored", 1, 8'h01);
    checkOutput();
    applyStimulus(3'b000, 1'b1, 8'hB9, 1'b0, 1'b0);
    step(1);
    expectOut("unmask_req", 0, 8'h01);
    checkOutput();
    applyStimulus(3'b000, 1'b1, 8'hB8, 1'b0, 1'b0);
    step(1);
    expectOut("remask_req", 0, 8'h00);
    expectOut("remask_status", 1, 8'h01);
    checkOutput();

    // New edge on cur coinciding with ack keeps pending set.
    applyStimulus(3'b000, 1'b1, 8'hBF, 1'b0, 1'b0);
    step(1);
    expectOut("setwins_req", 0, 8'h01);
    checkOutput();
    applyStimulus(3'b001, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 8'h00, 1'b1, 1'b0);
    expectOut("setwins_status", 1, 8'h49);
    checkOutput();
    applyStimulus(3'b000, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1);
    applyStimulus(3'b000, 1'b0, 8'h00, 1'b1, 1'b0);
    expectOut("service_status", 1, 8'h48);
    checkOutput();
    applyStimulus(3'b100, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1);
    expectOut("service_pending", 1, 8'h4C);
    checkOutput();

    // Asynchronous reset mid-service.
    #2 reset = 1'b0;
    #1;
    expectOut("async_reset_req", 0, 8'h00);
    expectOut("async_reset_status", 1, 8'h00);
    checkOutput();
    @(posedge clk);
    #1 reset = 1'b1;
    step(2);
    expectOut("post_reset_req", 0, 8'h00);
    expectOut("post_reset_status", 1, 8'h00);
    checkOutput();

    // Second instance: irq2 highest, three sync stages.
    applyStimulus2(3'b000, 1'b1, 8'h87, 1'b0, 1'b0);
    applyStimulus2(3'b111, 1'b0, 8'h00, 1'b0, 1'b0);
    step(3);
    expectOut("hi_before_latency", 2, 8'h00);
    checkOutput();
    step(1);
    expectOut("hi_req", 2, 8'h04);
    expectOut("hi_req_status", 3, 8'h47);
    checkOutput();
    applyStimulus2(3'b111, 1'b0, 8'h00, 1'b1, 1'b0);
    expectOut("hi_ack_status", 3, 8'h67);
    checkOutput();
    applyStimulus2(3'b111, 1'b0, 8'h00, 1'b0, 1'b1);
    expectOut("hi_eoi_status", 3, 8'h07);
    checkOutput();
    applyStimulus2(3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
    step(5);
    expectOut("hi_drop_status", 3, 8'h00);
    checkOutput();

    applyStimulus2(3'b000, 1'b1, 8'hBF, 1'b0, 1'b0);
    applyStimulus2(3'b001, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus2(3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
    step(3);
    expectOut("to_req", 2, 8'h01);
    expectOut("to_req_status", 3, 8'h41);
    checkOutput();
    step(3);
    expectOut("to_req_held", 2, 8'h01);
    checkOutput();
    step(1);
`ifdef INTC_TIMEOUT_EN
    expectOut("to_expired_req", 2, 8'h00);
    expectOut("to_expired_status", 3, 8'h80);
    checkOutput();
    applyStimulus2(3'b000, 1'b1, 8'hC7, 1'b0, 1'b0);
    expectOut("to_flag_cleared", 3, 8'h00);
    checkOutput();
`else
    expectOut("no_timeout_req", 2, 8'h01);
    expectOut("no_timeout_status", 3, 8'h41);
    checkOutput();
    applyStimulus2(3'b000, 1'b1, 8'hC7, 1'b0, 1'b0);
    expectOut("flag_tied_low", 4, 8'h00);
    expectOut("cfg_req_still", 2, 8'h01);
    checkOutput();
    step(3);
    expectOut("level_switch_drop", 2, 8'h00);
    checkOutput();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
